// File: rtl/lcd_pkg.sv
// Shared types and constants for the SPI-fed HD44780 4-bit controller:
// FSM states, wait selectors, the power-on init ROM and status bit positions.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, NIB_SETUP, NIB_PULSE, NIB_GAP, EXEC_WAIT
    } state_t;

    typedef enum logic [1:0] {W_INIT1, W_INIT2, W_CMD, W_SLOW} wait_sel_t;

    typedef struct packed {
        logic      is_nibble;
        logic [7:0] value;
        wait_sel_t wait_sel;
    } init_entry_t;

    localparam logic [7:0] PREFIX     = 8'hFE;
    localparam int         INIT_LEN   = 8;
    localparam int         FIFO_DEPTH = 8;
    localparam int         PTR_W      = $clog2(FIFO_DEPTH);

    localparam int ST_INIT_DONE = 7;
    localparam int ST_OVERFLOW  = 6;
    localparam int ST_FULL      = 5;

    // Single-nibble entries keep the nibble in value[7:4] so they share the high-nibble path.
    function automatic init_entry_t init_rom(input logic [2:0] idx);
        init_entry_t e;
        case (idx)
            3'd0:    e = '{1'b1, 8'h30, W_INIT1};
            3'd1:    e = '{1'b1, 8'h30, W_INIT2};
            3'd2:    e = '{1'b1, 8'h30, W_CMD};
            3'd3:    e = '{1'b1, 8'h20, W_CMD};
            3'd4:    e = '{1'b0, 8'h28, W_CMD};
            3'd5:    e = '{1'b0, 8'h0C, W_CMD};
            3'd6:    e = '{1'b0, 8'h01, W_SLOW};
            default: e = '{1'b0, 8'h06, W_CMD};
        endcase
        return e;
    endfunction

    function automatic logic is_slow(input logic rs, input logic [7:0] dat);
        return !rs && (dat >= 8'h01) && (dat <= 8'h03);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// 8 x 9-bit synchronous FIFO, show-ahead read data, one-cycle write/read.
// Writes while full are ignored here; the caller flags the overflow.
module lcd_cmd_fifo
    import lcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  logic [8:0] i_wr_dat,
    input  logic       i_rd_en,
    output logic [8:0] o_rd_dat,
    output logic       o_full,
    output logic       o_empty,
    output logic [3:0] o_count
);
    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [3:0]       r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full   = (r_count == 4'(FIFO_DEPTH));
    assign o_empty  = (r_count == 4'd0);
    assign o_count  = r_count;
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_wr     = i_wr_en && !o_full;
    assign w_rd     = i_rd_en && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
    end

endmodule

// File: rtl/spi_lcd_ctrl.sv
// SPI byte stream to HD44780 4-bit bus: power-on init, 0xFE instruction prefix, 8-deep buffer.
// Accept-to-FIFO is 2 clk; bytes arriving while full are dropped and latch the overflow flag.
module spi_lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int T_PWR   = CLK_HZ / 1000 * 15,
    parameter int T_INIT1 = CLK_HZ / 10000 * 41,
    parameter int T_INIT2 = CLK_HZ / 10000,
    parameter int T_SU    = 4,
    parameter int T_E     = 25,
    parameter int T_CMD   = CLK_HZ / 25000,
    parameter int T_SLOW  = CLK_HZ / 100000 * 164
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       ssel,
    output logic [7:0] status,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d
);
    localparam int T_MAX = max2(max2(max2(T_PWR, T_INIT1), max2(T_INIT2, T_SLOW)),
                                max2(T_CMD, max2(T_SU, T_E)));
    localparam int CW    = $clog2(T_MAX + 1);

    logic          r_bv, r_bv_d, r_prefix, r_overflow;
    logic [7:0]    r_byte, r_status, r_dat;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_dur;
    logic [2:0]    r_step;
    logic          r_rs, r_single, r_hi, r_init_done;
    wait_sel_t     r_wsel;
    logic          w_accept, w_is_prefix, w_enq, w_done, w_pop, w_bus;
    logic          w_full, w_empty;
    logic [8:0]    w_fifo_dat;
    logic [3:0]    w_count;
    logic [7:0]    w_status;
    init_entry_t   w_rom;

    assign w_accept    = r_bv && !r_bv_d;
    assign w_is_prefix = (r_byte == PREFIX);
    assign w_enq       = w_accept && !w_is_prefix;
    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_done      = (r_cnt == w_dur - CW'(1));
    assign w_rom       = init_rom(r_step);

    lcd_cmd_fifo u_fifo (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wr_en  (w_enq),
        .i_wr_dat ({!r_prefix, r_byte}),
        .i_rd_en  (w_pop),
        .o_rd_dat (w_fifo_dat),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bv       <= 1'b0;
            r_bv_d     <= 1'b0;
            r_byte     <= 8'h00;
            r_prefix   <= 1'b0;
            r_overflow <= 1'b0;
            r_status   <= 8'h00;
        end else begin
            r_bv     <= byte_valid;
            r_bv_d   <= r_bv;
            r_byte   <= byte_in;
            r_status <= w_status;
            if (w_accept) r_prefix <= !r_prefix && w_is_prefix;
            if (ssel) r_prefix <= 1'b0;
            // A doubled prefix is the host's way of acknowledging an overflow.
            if (w_enq && w_full) r_overflow <= 1'b1;
            else if (w_accept && r_prefix && w_is_prefix) r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_status               = 8'h00;
        w_status[ST_INIT_DONE] = r_init_done;
        w_status[ST_OVERFLOW]  = r_overflow;
        w_status[ST_FULL]      = w_full;
        w_status[3:0]          = w_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PWR_WAIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_dur  = CW'(1);
        w_next = r_state;
        unique case (r_state)
            PWR_WAIT: begin
                w_dur = CW'(T_PWR);
                if (w_done) w_next = INIT;
            end
            INIT: w_next = NIB_SETUP;
            IDLE: if (!w_empty) w_next = NIB_SETUP;
            NIB_SETUP: begin
                w_dur = CW'(T_SU);
                if (w_done) w_next = NIB_PULSE;
            end
            NIB_PULSE: begin
                w_dur = CW'(T_E);
                if (w_done) w_next = NIB_GAP;
            end
            NIB_GAP: begin
                w_dur = CW'(T_E);
                if (w_done) w_next = (r_hi && !r_single) ? NIB_SETUP : EXEC_WAIT;
            end
            EXEC_WAIT: begin
                unique case (r_wsel)
                    W_INIT1: w_dur = CW'(T_INIT1);
                    W_INIT2: w_dur = CW'(T_INIT2);
                    W_CMD:   w_dur = CW'(T_CMD);
                    W_SLOW:  w_dur = CW'(T_SLOW);
                endcase
                if (w_done)
                    w_next = (r_init_done || r_step == 3'(INIT_LEN - 1)) ? IDLE : INIT;
            end
            default: w_next = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_step      <= 3'd0;
            r_dat       <= 8'h00;
            r_rs        <= 1'b0;
            r_single    <= 1'b0;
            r_hi        <= 1'b0;
            r_wsel      <= W_CMD;
            r_init_done <= 1'b0;
        end else begin
            r_cnt <= w_done ? '0 : r_cnt + CW'(1);
            case (r_state)
                INIT: begin
                    r_dat    <= w_rom.value;
                    r_rs     <= 1'b0;
                    r_single <= w_rom.is_nibble;
                    r_wsel   <= w_rom.wait_sel;
                    r_hi     <= 1'b1;
                end
                IDLE: if (w_pop) begin
                    r_dat    <= w_fifo_dat[7:0];
                    r_rs     <= w_fifo_dat[8];
                    r_single <= 1'b0;
                    r_wsel   <= is_slow(w_fifo_dat[8], w_fifo_dat[7:0]) ? W_SLOW : W_CMD;
                    r_hi     <= 1'b1;
                end
                NIB_GAP: if (w_done && r_hi && !r_single) r_hi <= 1'b0;
                EXEC_WAIT: if (w_done && !r_init_done) begin
                    if (r_step == 3'(INIT_LEN - 1)) r_init_done <= 1'b1;
                    else                            r_step      <= r_step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_bus  = (r_state == NIB_SETUP) || (r_state == NIB_PULSE) || (r_state == NIB_GAP);
        lcd_e  = (r_state == NIB_PULSE);
        lcd_rs = w_bus && r_rs;
        lcd_d  = w_bus ? (r_hi ? r_dat[7:4] : r_dat[3:0]) : 4'h0;
    end

    assign lcd_rw = 1'b0;
    assign status = r_status;

endmodule

// File: tb/tb_spi_lcd_ctrl.sv
// Directed bench for spi_lcd_ctrl with shortened timing; a negedge monitor logs every E pulse.
module tb_spi_lcd_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic       ssel = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic [7:0] status;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    logic [4:0] q_nib[$];
    int         q_w[$], q_su[$], q_rise[$], q_fall[$];
    logic       prev_e = 1'b0;
    logic [4:0] prev_bus = 5'h00, cur_nib = 5'h00;
    int         stable = 0, rise_c = 0, cur_su = 0;

    logic [4:0] exp_init [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                  5'h00, 5'h0C, 5'h00, 5'h01, 5'h00, 5'h06};
    int         exp_gap  [11] = '{16, 11, 12, 12, 5, 12, 5, 12, 5, 21, 5};

    spi_lcd_ctrl #(
        .T_PWR(20), .T_INIT1(10), .T_INIT2(5), .T_SU(2), .T_E(3), .T_CMD(6), .T_SLOW(15)
    ) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_in(byte_in), .ssel(ssel),
        .status(status), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (lcd_e && !prev_e) begin
            rise_c  = cyc;
            cur_nib = {lcd_rs, lcd_d};
            cur_su  = stable;
        end
        if (!lcd_e && prev_e) begin
            q_nib.push_back(cur_nib);
            q_w.push_back(cyc - rise_c);
            q_su.push_back(cur_su);
            q_rise.push_back(rise_c);
            q_fall.push_back(cyc);
        end
        if (!lcd_e) stable = ({lcd_rs, lcd_d} == prev_bus) ? stable + 1 : 1;
        prev_bus = {lcd_rs, lcd_d};
        prev_e   = lcd_e;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        byte_valid = 1'b1;
        byte_in    = b;
        tick(2);
        byte_valid = 1'b0;
        tick(2);
    endtask

    task automatic clear_q();
        q_nib.delete(); q_w.delete(); q_su.delete(); q_rise.delete(); q_fall.delete();
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int b = 0;
        while (q_nib.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk(tag, 32'(q_nib.size() >= n), 32'd1);
    endtask

    task automatic release_rst();
        tick();
        rst = 1'b0;
        t0  = cyc;
        clear_q();
    endtask

    initial begin
        int bad;
        int fall;
        int b;

        // Reset values while rst is held
        tick(3);
        chk("rst_bus", {28'h0, lcd_e, lcd_rs, lcd_rw, 1'b0} | {28'h0, lcd_d}, 32'h0);
        chk("rst_status", status, 8'h00);

        // Power-on wait: bus idle for T_PWR cycles
        release_rst();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lcd_e || lcd_rs || lcd_rw || lcd_d != 4'h0) bad++;
        end
        chk("pwr_quiet", bad, 0);
        chk("pwr_no_pulse", q_nib.size(), 0);

        // Init sequence: nibble values, widths, inter-pulse gaps
        wait_pulses(12, 600, "init_pulses");
        chk("init_first_rise", q_rise[0] - t0, 23);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("init_nib%0d", i), q_nib[i], exp_init[i]);
            chk($sformatf("init_w%0d", i), q_w[i], 3);
        end
        for (int i = 0; i < 11; i++)
            chk($sformatf("init_gap%0d", i), q_rise[i+1] - q_fall[i], exp_gap[i]);
        fall = q_fall[11];
        while (cyc < fall + 9) tick();
        chk("init_done_early", status, 8'h00);
        tick();
        chk("init_done_status", status, 8'h80);

        // Plain data byte
        clear_q();
        send_byte(8'h41);
        wait_pulses(2, 100, "data_pulses");
        chk("data_hi", q_nib[0], 5'h14);
        chk("data_lo", q_nib[1], 5'h11);
        chk("data_su_hi", q_su[0], 2);
        chk("data_su_lo", q_su[1], 2);
        chk("data_w_hi", q_w[0], 3);
        chk("data_w_lo", q_w[1], 3);
        chk("data_nib_gap", q_rise[1] - q_fall[0], 5);
        tick(30);
        chk("data_status", status, 8'h80);

        // Prefixed instruction followed by data: slow wait after 0x01
        clear_q();
        send_byte(8'hFE);
        send_byte(8'h01);
        send_byte(8'h42);
        wait_pulses(4, 200, "pfx_pulses");
        chk("pfx_hi", q_nib[0], 5'h00);
        chk("pfx_lo", q_nib[1], 5'h01);
        chk("pfx_next_hi", q_nib[2], 5'h14);
        chk("pfx_next_lo", q_nib[3], 5'h12);
        chk("pfx_slow_gap", q_rise[2] - q_fall[1], 21);
        tick(60);
        chk("pfx_total", q_nib.size(), 4);

        // Long byte_valid: single accept
        clear_q();
        tick();
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        tick(50);
        byte_valid = 1'b0;
        tick(40);
        chk("long_total", q_nib.size(), 2);
        chk("long_hi", q_nib[0], 5'h15);
        chk("long_lo", q_nib[1], 5'h15);

        // ssel high cancels a pending prefix
        clear_q();
        send_byte(8'hFE);
        ssel = 1'b1;
        tick(3);
        ssel = 1'b0;
        send_byte(8'h41);
        tick(60);
        chk("ssel_total", q_nib.size(), 2);
        chk("ssel_hi", q_nib[0], 5'h14);
        chk("ssel_lo", q_nib[1], 5'h11);

        // Overflow while init is running
        rst = 1'b1;
        tick(2);
        release_rst();
        for (int i = 0; i < 10; i++) send_byte(8'h30 + 8'(i));
        tick(3);
        chk("ovf_status_init", status, 8'h68);
        b = 0;
        while (!status[7] && b < 1000) begin
            tick();
            b++;
        end
        chk("ovf_status_done", status, 8'hE8);
        wait_pulses(28, 1000, "ovf_pulses");
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_hi%0d", k), q_nib[12 + 2*k], 5'h13);
            chk($sformatf("ovf_lo%0d", k), q_nib[13 + 2*k], 5'h10 + 5'(k));
        end
        tick(40);
        chk("ovf_total", q_nib.size(), 28);
        chk("ovf_sticky", status, 8'hC0);
        send_byte(8'hFE);
        send_byte(8'hFE);
        tick(3);
        chk("ovf_cleared", status, 8'h80);
        tick(30);
        chk("ovf_fefe_silent", q_nib.size(), 28);

        // Reset in the middle of an E pulse
        send_byte(8'h41);
        b = 0;
        while (!lcd_e && b < 100) begin
            tick();
            b++;
        end
        chk("abort_saw_e", lcd_e, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_e_low", lcd_e, 1'b0);
        chk("abort_status", status, 8'h00);
        tick(2);
        release_rst();
        wait_pulses(1, 200, "abort_restart");
        chk("abort_first_rise", q_rise[0] - t0, 23);
        chk("abort_first_nib", q_nib[0], 5'h03);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_lcd_ctrl.md
# spi_lcd_ctrl

Consumes the byte stream produced by the SPI slave receiver and drives a write-only HD44780-compatible character LCD in 4-bit mode. The block performs the LCD power-on initialisation, buffers incoming bytes in an 8-entry FIFO, and decodes a 0xFE prefix that marks the following byte as an instruction. It returns a status byte that the SPI slave shifts out on MISO.

## Interface
- CLK_HZ, 50_000_000: clock frequency, for documentation only; all delays are given as explicit cycle counts.
- T_PWR, 750000: cycles from reset release to the first init nibble (15 ms).
- T_INIT1, 205000: wait after the first init nibble (4.1 ms).
- T_INIT2, 5000: wait after the second init nibble (100 us).
- T_SU, 4: cycles of RS/data setup before E rises.
- T_E, 25: cycles E is held high, and also the E-low gap between the two nibbles.
- T_CMD, 2000: execution wait after a normal byte (40 us).
- T_SLOW, 82000: execution wait after instructions 0x01 to 0x03 (1.64 ms).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- byte_valid  in  1  level "byte complete" from the SPI slave; may stay high for many clk cycles.
- byte_in  in  8  received byte; valid when byte_valid is high.
- ssel  in  1  SPI chip select, active low.
- status  out  8  {init_done, overflow, fifo_full, 1'b0, fifo_count[3:0]}; feeds the SPI slave's send byte.
- lcd_rs  out  1  LCD register select: 0 = instruction, 1 = data.
- lcd_rw  out  1  tied to 0.
- lcd_e  out  1  LCD enable strobe.
- lcd_d  out  4  LCD data bus D7..D4.

## Operation
- **Byte capture:** a byte is accepted on the clk after a 0 to 1 edge of the registered byte_valid. Exactly one accept occurs per edge.
- **Prefix decode:**
  - An accepted 0xFE with prefix_pending=0 sets prefix_pending and is not enqueued.
  - The next accepted byte is enqueued as {rs=0, byte} and clears prefix_pending.
  - If that byte is 0xFE, it is not enqueued and instead clears overflow.
  - All other bytes are enqueued as {rs=1, byte}.
  - ssel high clears prefix_pending.
- **FIFO:** 8 entries of 9 bits. Enqueueing while full drops the entry and sets the sticky overflow flag. Enqueue and dequeue in the same cycle leaves fifo_count unchanged.
- **FSM states:** PWR_WAIT, INIT, IDLE, NIB_SETUP, NIB_PULSE, NIB_GAP, EXEC_WAIT. A shared cycle counter times every state. Each byte is sent as the high nibble, then the low nibble.
- **Init sequence:**
  1. PWR_WAIT for T_PWR.
  2. Send single nibbles with rs=0: 0x3 then wait T_INIT1; 0x3 then wait T_INIT2; 0x3 then wait T_CMD; 0x2 then wait T_CMD.
  3. Send full bytes 0x28, 0x0C, 0x01 (T_SLOW) and 0x06.
  4. Set init_done; enter IDLE.
- **Bytes during init:** bytes received during init are buffered and are not sent until init_done=1.
- **IDLE:** if the FIFO is non-empty, pop one entry, latch it, and go to NIB_SETUP for the high nibble.
- **Per-nibble sequence:** NIB_SETUP (T_SU cycles, E=0, RS and D valid), then NIB_PULSE (T_E cycles, E=1), then NIB_GAP (T_E cycles, E=0).
- **After the nibbles:** after the high nibble's gap, send the low nibble. After the low nibble's gap, go to EXEC_WAIT for T_SLOW if rs=0 and the byte is 0x01 to 0x03, else for T_CMD. Then return to IDLE, or to the next INIT step.
- **Output stability:** RS and D hold from the start of NIB_SETUP through the end of NIB_GAP.
- **Reset:**
  - Outputs: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0.
  - Status: status=8'h00.
  - FIFO empty; prefix_pending=0; overflow=0; state PWR_WAIT.
  - A reset in mid-transfer aborts immediately and restarts the full init sequence.

## Timing
- Accept latency: the FIFO entry is visible (fifo_count increments) 2 clk after the byte_valid rising edge, because of 1 register stage plus the edge detect.
- IDLE pop to lcd_e rising: 1 + T_SU clk.
- Bus time per byte: 2·(T_SU+2·T_E) clk, plus T_CMD or T_SLOW.
- status is registered and updates 1 clk after the internal change.

## Structure
- Package lcd_pkg holds:
  - the state enum;
  - PREFIX = 8'hFE;
  - the init ROM, as entries of {is_nibble, value, wait_select};
  - the status bit indices.
- Sub-module lcd_cmd_fifo: a synchronous 9-bit × 8 FIFO with full/empty/count outputs. It uses the same clk/rst.

## Test plan
All scenarios use T_PWR=20, T_INIT1=10, T_INIT2=5, T_SU=2, T_E=3, T_CMD=6, T_SLOW=15.
- **Reset and init:** release reset → outputs are 0 for 20 clk. Then the nibbles 3, 3, 3, 2 appear with the programmed gaps, followed by bytes 0x28, 0x0C, 0x01, 0x06 with rs=0. 0x01 is followed by a 15-clk wait. init_done is then 1 and status is 0x80.
- **Data byte:** send 0x41 → one transfer with rs=1, lcd_d=4 then 1. Each E pulse is 3 clk wide, and each E rise is 2 clk after the nibble is driven.
- **Prefix instruction:** send 0xFE, 0x01 → one transfer with rs=0, byte 0x01, followed by a 15-clk EXEC_WAIT. Nothing is enqueued for 0xFE.
- **Long byte_valid:** hold byte_valid high for 50 clk with 0x55 → exactly one entry is enqueued.
- **Overflow:** send 10 bytes during PWR_WAIT → fifo_count=8, status=0xE8. Only the first 8 bytes are later displayed, in order. Sending 0xFE, 0xFE afterwards clears overflow.
- **Aborts:**
  - Send 0xFE, raise ssel, then send 0x41 → the byte is displayed as data (rs=1).
  - Assert rst mid-NIB_PULSE → lcd_e=0 in the same cycle, and init restarts.
